unsaved_cpu_cpu_div_cell: RTL and testbench

Sequential 32-bit integer divide unit for the Nios II CPU core: the divide counterpart to the registered multiply cell, sitting beside it in the execute/memory stage. Accepts two 32-bit operands on a start pulse, runs a radix-2 restoring division on magnitudes, applies sign correction, and presents quotient and remainder with a one-cycle done pulse. The pipeline stalls on `busy` and can abandon an operation with `kill` on a flush.

---
 rtl/unsaved_cpu_cpu_div_cell_if.sv | 24 ++
 rtl/unsaved_cpu_cpu_div_cell.sv | 179 +++++++++++++++++
 tb/tb_unsaved_cpu_cpu_div_cell.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unsaved_cpu_cpu_div_cell_if.sv
// Operand/result bundle for the sequential divide cell.
// The master side (pipeline) drives the operands and control.
// The slave side (divide cell) returns the results and status.
interface unsaved_cpu_cpu_div_cell_if;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_signed;
  logic        start;
  logic        kill;
  logic [31:0] M_div_quot;
  logic [31:0] M_div_rem;
  logic        busy;
  logic        done;

  modport master (
    output E_src1, E_src2, E_signed, start, kill,
    input  M_div_quot, M_div_rem, busy, done
  );

  modport slave (
    input  E_src1, E_src2, E_signed, start, kill,
    output M_div_quot, M_div_rem, busy, done
  );
endinterface

// File: rtl/unsaved_cpu_cpu_div_cell.sv
// Sequential 32-bit divide cell (DIV/DIVU).
// Operation:
//   - Radix-2 restoring division is run on the operand magnitudes.
//   - Signs are reapplied in the FIX state.
//   - Quotient and remainder stay registered until the next accepted start.
//   - Throughput is one operation every 35 cycles: 1 accept, 32 ITER, 1 FIX, 1 DONE.
module unsaved_cpu_cpu_div_cell (
  input  logic clk,
  input  logic reset,
  unsaved_cpu_cpu_div_cell_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d;        // partial remainder
  logic [31:0] quot_q, quot_d;      // dividend bits shift out, quotient bits shift in
  logic [31:0] dvs_q, dvs_d;        // divisor magnitude
  logic [31:0] dvd_q, dvd_d;        // dividend as given, returned on divide-by-zero
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] res_quot_q, res_quot_d;
  logic [31:0] res_rem_q, res_rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] mag1, mag2;
  logic [32:0] shifted, trial;
  logic [31:0] quot_fix, rem_fix;

  // Operand magnitudes: take the absolute value only for signed operations.
  assign mag1 = (bus.E_signed && bus.E_src1[31]) ? (~bus.E_src1 + 32'd1) : bus.E_src1;
  assign mag2 = (bus.E_signed && bus.E_src2[31]) ? (~bus.E_src2 + 32'd1) : bus.E_src2;

  // One restoring step.
  //   - Shift {rem,quot} left by one bit.
  //   - Trial-subtract the divisor using 33 bits.
  //   - Bit 32 of the trial is the borrow (trial result negative).
  assign shifted = {rem_q, quot_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Sign correction of the magnitude results.
  assign quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
  assign rem_fix  = neg_rem_q  ? (~rem_q  + 32'd1) : rem_q;

  // Next-state and datapath logic for the whole cell.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Start wins over a simultaneous kill; kill alone has nothing to abort here.
        if (bus.start) begin
          quot_d     = mag1;
          dvs_d      = mag2;
          dvd_d      = bus.E_src1;
          rem_d      = 32'd0;
          count_d    = 5'd0;
          neg_quot_d = bus.E_signed & (bus.E_src1[31] ^ bus.E_src2[31]);
          neg_rem_d  = bus.E_signed & bus.E_src1[31];
          dbz_d      = (bus.E_src2 == 32'd0);
          ovf_d      = bus.E_signed && (bus.E_src1 == 32'h8000_0000) &&
                       (bus.E_src2 == 32'hFFFF_FFFF);
          busy_d     = 1'b1;
          state_d    = ITER;
        end
      end

      ITER: begin
        if (bus.kill) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d   = trial[32] ? shifted[31:0] : trial[31:0];
          quot_d  = {quot_q[30:0], ~trial[32]};
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        busy_d = 1'b0;
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          // Divide-by-zero takes priority.
          // It returns an all-ones quotient and the dividend unmodified.
          if (dbz_q) begin
            res_quot_d = 32'hFFFF_FFFF;
            res_rem_d  = dvd_q;
          end else if (ovf_q) begin
            res_quot_d = 32'h8000_0000;
            res_rem_d  = 32'd0;
          end else begin
            res_quot_d = quot_fix;
            res_rem_d  = rem_fix;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // Start is deliberately not sampled here.
        // It is accepted again from IDLE on the next cycle.
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      dvs_q      <= 32'd0;
      dvd_q      <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      res_quot_q <= 32'd0;
      res_rem_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.M_div_quot = res_quot_q;
  assign bus.M_div_rem  = res_rem_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_unsaved_cpu_cpu_div_cell.sv
// Directed testbench for the sequential divide cell.
module tb_unsaved_cpu_cpu_div_cell;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   miss_cnt;

  unsaved_cpu_cpu_div_cell_if dif ();

  unsaved_cpu_cpu_div_cell dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start (optionally together with kill) and follow the operation
  // until done.
  // Outputs returned to the caller:
  //   - latency in edges after the accepting edge
  //   - number of busy cycles
  //   - whether done was seen
  //   - whether done was still high one cycle later
  // On return the cell is back in IDLE.
  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic kill_with, output int lat, output int busy_n,
                          output bit seen, output logic done_after);
    dif.E_src1   = a;
    dif.E_src2   = b;
    dif.E_signed = s;
    dif.start    = 1'b1;
    dif.kill     = kill_with;
    @(posedge clk); #1;
    dif.start  = 1'b0;
    dif.kill   = 1'b0;
    lat        = -1;
    busy_n     = 0;
    seen       = 1'b0;
    done_after = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (dif.busy) busy_n++;
      if (dif.done) begin
        seen = 1'b1;
        lat  = n - 1;
        break;
      end
      @(posedge clk); #1;
    end
    $display("op %h / %h signed=%0d -> quot=%h rem=%h latency=%0d busy=%0d",
             a, b, s, dif.M_div_quot, dif.M_div_rem, lat, busy_n);
    @(posedge clk); #1;
    done_after = dif.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (dif.busy !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_busy got %b want 0", dif.busy);
    end
    vec_cnt++;
    if (dif.done !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_done got %b want 0", dif.done);
    end
    vec_cnt++;
    if (dif.M_div_quot !== 32'd0) begin
      miss_cnt++; $display("FAIL reset_quot got %h want 0", dif.M_div_quot);
    end
    vec_cnt++;
    if (dif.M_div_rem !== 32'd0) begin
      miss_cnt++; $display("FAIL reset_rem got %h want 0", dif.M_div_rem);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat, bn; bit seen; logic da;
    issue_op(32'd100, 32'd7, 1'b0, 1'b0, lat, bn, seen, da);
    vec_cnt++;
    if (!seen || lat != 33) begin
      miss_cnt++; $display("FAIL u100_7_latency got %0d want 33", lat);
    end
    vec_cnt++;
    if (bn != 33) begin
      miss_cnt++; $display("FAIL u100_7_busy_cycles got %0d want 33", bn);
    end
    vec_cnt++;
    if (da !== 1'b0) begin
      miss_cnt++; $display("FAIL u100_7_done_pulse got %b want 0", da);
    end
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (dif.M_div_quot !== 32'd14) begin
      miss_cnt++; $display("FAIL u100_7_quot got %h want %h", dif.M_div_quot, 32'd14);
    end
    vec_cnt++;
    if (dif.M_div_rem !== 32'd2) begin
      miss_cnt++; $display("FAIL u100_7_rem got %h want %h", dif.M_div_rem, 32'd2);
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [5] = '{32'd2, 32'hFFFF_FFFE, 32'd7, 32'd1, 32'hFFFF_FFFF};
    logic        vs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] vq [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vr [5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd0, 32'h8000_0000};
    int lat, bn; bit seen; logic da;
    for (int i = 0; i < 5; i++) begin
      issue_op(va[i], vb[i], vs[i], 1'b0, lat, bn, seen, da);
      vec_cnt++;
      if (dif.M_div_quot !== vq[i]) begin
        miss_cnt++; $display("FAIL div_vec%0d_quot got %h want %h", i, dif.M_div_quot, vq[i]);
      end
      vec_cnt++;
      if (dif.M_div_rem !== vr[i]) begin
        miss_cnt++; $display("FAIL div_vec%0d_rem got %h want %h", i, dif.M_div_rem, vr[i]);
      end
      vec_cnt++;
      if (!seen || lat != 33) begin
        miss_cnt++; $display("FAIL div_vec%0d_latency got %0d want 33", i, lat);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [4] = '{32'd1234, 32'd1234, 32'hFFFF_FB2E, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] vq [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vr [4] = '{32'd1234, 32'd1234, 32'hFFFF_FB2E, 32'd0};
    int lat, bn; bit seen; logic da;
    for (int i = 0; i < 4; i++) begin
      issue_op(va[i], vb[i], vs[i], 1'b0, lat, bn, seen, da);
      vec_cnt++;
      if (dif.M_div_quot !== vq[i]) begin
        miss_cnt++; $display("FAIL special%0d_quot got %h want %h", i, dif.M_div_quot, vq[i]);
      end
      vec_cnt++;
      if (dif.M_div_rem !== vr[i]) begin
        miss_cnt++; $display("FAIL special%0d_rem got %h want %h", i, dif.M_div_rem, vr[i]);
      end
      vec_cnt++;
      if (!seen || lat != 33) begin
        miss_cnt++; $display("FAIL special%0d_latency got %0d want 33", i, lat);
      end
    end
  endtask

  // Start pulses while busy and in the DONE cycle must all be ignored.
  task automatic test_start_ignored();
    int lat; logic busy_after;
    lat = -1;
    busy_after = 1'b1;
    dif.E_src1 = 32'd100; dif.E_src2 = 32'd7; dif.E_signed = 1'b0;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    dif.E_src1 = 32'd9; dif.E_src2 = 32'd3; dif.E_signed = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 35) begin
        busy_after = dif.busy;
        break;
      end
      if (dif.done && lat < 0) lat = n - 1;
      dif.start = (n == 5 || n == 20 || n == 34);
      @(posedge clk); #1;
    end
    dif.start = 1'b0;
    $display("op 00000064 / 00000007 with ignored starts -> quot=%h rem=%h latency=%0d",
             dif.M_div_quot, dif.M_div_rem, lat);
    vec_cnt++;
    if (lat != 33) begin
      miss_cnt++; $display("FAIL ignore_start_latency got %0d want 33", lat);
    end
    vec_cnt++;
    if (dif.M_div_quot !== 32'd14) begin
      miss_cnt++; $display("FAIL ignore_start_quot got %h want %h", dif.M_div_quot, 32'd14);
    end
    vec_cnt++;
    if (dif.M_div_rem !== 32'd2) begin
      miss_cnt++; $display("FAIL ignore_start_rem got %h want %h", dif.M_div_rem, 32'd2);
    end
    vec_cnt++;
    if (busy_after !== 1'b0) begin
      miss_cnt++; $display("FAIL start_in_done_busy got %b want 0", busy_after);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_kill();
    int lat, bn, done_n; bit seen; logic da;
    // Kill at iteration 10.
    dif.E_src1 = 32'd1000; dif.E_src2 = 32'd3; dif.E_signed = 1'b0;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    dif.kill = 1'b1;
    @(posedge clk); #1;
    dif.kill = 1'b0;
    $display("op 000003e8 / 00000003 killed -> busy=%b done=%b", dif.busy, dif.done);
    vec_cnt++;
    if (dif.busy !== 1'b0) begin
      miss_cnt++; $display("FAIL kill_iter_busy got %b want 0", dif.busy);
    end
    vec_cnt++;
    if (dif.M_div_quot !== 32'd14 || dif.M_div_rem !== 32'd2) begin
      miss_cnt++;
      $display("FAIL kill_iter_hold got %h/%h want 0000000e/00000002", dif.M_div_quot, dif.M_div_rem);
    end
    done_n = 0;
    for (int n = 0; n < 40; n++) begin
      if (dif.done) done_n++;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (done_n != 0) begin
      miss_cnt++; $display("FAIL kill_iter_no_done got %0d want 0", done_n);
    end

    // A fresh op, with kill asserted alongside start in IDLE (start wins).
    issue_op(32'd50, 32'd5, 1'b0, 1'b1, lat, bn, seen, da);
    vec_cnt++;
    if (dif.M_div_quot !== 32'd10 || dif.M_div_rem !== 32'd0 || !seen || lat != 33) begin
      miss_cnt++;
      $display("FAIL kill_then_50_5 got %h/%h lat %0d want 0000000a/00000000 lat 33",
               dif.M_div_quot, dif.M_div_rem, lat);
    end

    // Kill in FIX: no done, results hold.
    dif.E_src1 = 32'd77; dif.E_src2 = 32'd4; dif.E_signed = 1'b0;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    dif.kill = 1'b1;
    @(posedge clk); #1;
    dif.kill = 1'b0;
    $display("op 0000004d / 00000004 killed in FIX -> busy=%b done=%b", dif.busy, dif.done);
    vec_cnt++;
    if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
      miss_cnt++; $display("FAIL kill_fix_status got done=%b busy=%b want 0/0", dif.done, dif.busy);
    end
    vec_cnt++;
    if (dif.M_div_quot !== 32'd10 || dif.M_div_rem !== 32'd0) begin
      miss_cnt++;
      $display("FAIL kill_fix_hold got %h/%h want 0000000a/00000000", dif.M_div_quot, dif.M_div_rem);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bn, done_n; bit seen; logic da;
    dif.E_src1 = 32'd1000; dif.E_src2 = 32'd3; dif.E_signed = 1'b0;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("op 000003e8 / 00000003 reset mid-ITER -> quot=%h rem=%h busy=%b",
             dif.M_div_quot, dif.M_div_rem, dif.busy);
    vec_cnt++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.M_div_quot !== 32'd0 || dif.M_div_rem !== 32'd0) begin
      miss_cnt++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b %h/%h want all 0",
               dif.busy, dif.done, dif.M_div_quot, dif.M_div_rem);
    end
    done_n = 0;
    for (int n = 0; n < 40; n++) begin
      if (dif.done) done_n++;
      @(posedge clk); #1;
    end
    vec_cnt++;
    if (done_n != 0) begin
      miss_cnt++; $display("FAIL reset_mid_no_done got %0d want 0", done_n);
    end
    issue_op(32'd1000, 32'd3, 1'b0, 1'b0, lat, bn, seen, da);
    vec_cnt++;
    if (dif.M_div_quot !== 32'd333 || dif.M_div_rem !== 32'd1 || !seen || lat != 33) begin
      miss_cnt++;
      $display("FAIL reset_mid_recover got %h/%h lat %0d want 0000014d/00000001 lat 33",
               dif.M_div_quot, dif.M_div_rem, lat);
    end
  endtask

  // Short random regression against the language's own division operators,
  // plus the q*d + r == n identity on the DUT results.
  task automatic test_random();
    logic [31:0] a, b, eq, er, chk;
    logic s;
    int sa, sb, lat, bn;
    bit seen; logic da;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 3 == 0) b = b >> 24;
      if (i % 7 == 0) b = 32'd0;
      if (b == 32'd0) begin
        eq = 32'hFFFF_FFFF; er = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = 32'h8000_0000; er = 32'd0;
      end else if (s) begin
        sa = a; sb = b;
        eq = 32'(sa / sb); er = 32'(sa % sb);
      end else begin
        eq = a / b; er = a % b;
      end
      issue_op(a, b, s, 1'b0, lat, bn, seen, da);
      vec_cnt++;
      if (dif.M_div_quot !== eq || dif.M_div_rem !== er || !seen || lat != 33) begin
        miss_cnt++;
        $display("FAIL rand%0d got %h/%h lat %0d want %h/%h lat 33",
                 i, dif.M_div_quot, dif.M_div_rem, lat, eq, er);
      end
      if (b != 32'd0) begin
        chk = dif.M_div_quot * b + dif.M_div_rem;
        vec_cnt++;
        if (chk !== a) begin
          miss_cnt++; $display("FAIL rand%0d_identity got %h want %h", i, chk, a);
        end
      end
    end
  endtask

  initial begin
    vec_cnt      = 0;
    miss_cnt     = 0;
    reset        = 1'b1;
    dif.E_src1   = 32'd0;
    dif.E_src2   = 32'd0;
    dif.E_signed = 1'b0;
    dif.start    = 1'b0;
    dif.kill     = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_start_ignored();
    test_kill();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
